// File: rtl/mux1hot_rr_arbiter.sv
// mux1hot_rr_arbiter: round-robin grant drives a one-hot mux into a registered valid/ready output; MUX1HOT_RR_LOCK_EN adds in_last packet locking
module mux1hot_rr_arbiter #(
  parameter int N     = 3,
  parameter int WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
`ifdef MUX1HOT_RR_LOCK_EN
  input  logic [N-1:0]         i_in_last,
`endif
  input  logic [N-1:0]         i_in_valid,
  input  logic [N*WIDTH-1:0]   i_in_data,
  output logic [N-1:0]         o_in_ready,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic [N-1:0]         o_out_src
);
  localparam int IW = $clog2(N);
  logic [IW-1:0]    r_last_gnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [N-1:0]     r_out_src;
  logic [N-1:0]     w_rr, w_gnt;
  logic [IW-1:0]    w_win_idx;
  logic [WIDTH-1:0] w_mux;
  logic             w_can_accept, w_accept;
  // Later offsets are overwritten by earlier ones, so the nearest valid requester after the pointer wins.
  always_comb begin
    w_rr = '0;
    for (int k = N; k >= 1; k--)
      for (int i = 0; i < N; i++)
        if (i_in_valid[i] && ((int'(r_last_gnt) + k) % N) == i) begin
          w_rr    = '0;
          w_rr[i] = 1'b1;
        end
  end
`ifdef MUX1HOT_RR_LOCK_EN
  typedef enum logic {S_UNLOCKED, S_LOCKED} state_t;
  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_lock_oh, w_lock_nxt;
  assign w_gnt = (r_state == S_LOCKED) ? (r_lock_oh & i_in_valid) : w_rr;
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_oh;
    if (w_accept) begin
      w_state_nxt = |(i_in_last & w_gnt) ? S_UNLOCKED : S_LOCKED;
      w_lock_nxt  = w_gnt;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state   <= S_UNLOCKED;
      r_lock_oh <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_oh <= w_lock_nxt;
    end
  end
`else
  assign w_gnt = w_rr;
`endif
  assign w_can_accept = !r_out_valid || i_out_ready;
  assign o_in_ready   = w_gnt & {N{w_can_accept & i_reset}};
  assign w_accept     = |(i_in_valid & o_in_ready);
  always_comb begin
    w_mux     = '0;
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_mux = w_mux | (i_in_data[i*WIDTH +: WIDTH] & {WIDTH{w_gnt[i]}});
      if (w_gnt[i]) w_win_idx = IW'(i);
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last_gnt  <= IW'(N - 1);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_accept) begin
      r_last_gnt  <= w_win_idx;
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
      r_out_src   <= w_gnt;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;
endmodule

// File: tb/tb_mux1hot_rr_arbiter.sv
// tb_mux1hot_rr_arbiter: directed plan plus randomized traffic against a pointer-based reference model
module tb_mux1hot_rr_arbiter;
  localparam int N = 3;
  localparam int W = 3;
  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   in_valid, in_ready, out_src, in_last;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [W-1:0]   out_data;
  int             checks = 0;
  int             failures = 0;
  int             m_last, m_lock;
  logic           m_ov;
  logic [W-1:0]   m_od;
  logic [N-1:0]   m_os, obs_rdy;

  mux1hot_rr_arbiter #(.N(N), .WIDTH(W)) dut (
    .i_clk(clk),
    .i_reset(reset),
`ifdef MUX1HOT_RR_LOCK_EN
    .i_in_last(in_last),
`endif
    .i_in_valid(in_valid),
    .i_in_data(in_data),
    .o_in_ready(in_ready),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data(out_data),
    .o_out_src(out_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int k = 1; k <= N; k++)
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1;
    m_lock = -1;
    m_ov   = 1'b0;
    m_od   = '0;
    m_os   = '0;
  endtask

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic ordy, input logic [N-1:0] l);
    int g;
    logic [N-1:0] er;
    @(negedge clk);
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_src", out_src, m_os);
    reset = r; in_valid = v; in_data = d; out_ready = ordy; in_last = l;
    #1;
    g  = pick(v);
    er = '0;
    if (r && g >= 0 && (!m_ov || ordy)) er[g] = 1'b1;
    obs_rdy = in_ready;
    check("in_ready", in_ready, er);
    if (!r) model_reset();
    else if (er != 0) begin
      m_od   = d[g*W +: W];
      m_os   = er;
      m_ov   = 1'b1;
      m_last = g;
`ifdef MUX1HOT_RR_LOCK_EN
      m_lock = l[g] ? -1 : g;
`endif
    end else if (ordy) m_ov = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] rot_d;
    logic [N-1:0]   rot_rdy [4];
    logic [W-1:0]   rot_out [4];
    rot_d = 9'b010_001_000;
    rot_rdy = '{3'b001, 3'b010, 3'b100, 3'b001};
    rot_out = '{3'b000, 3'b001, 3'b010, 3'b000};
    reset = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1; in_last = '0;
    @(posedge clk);
    model_reset();
    step(0, 3'b111, 9'o765, 1, 0);
    check("rst_rdy", obs_rdy, 3'b000);
    step(0, 3'b111, 9'o765, 1, 0);
    step(1, 3'b111, 9'o765, 1, 0);
    check("first_rdy", obs_rdy, 3'b001);
    step(1, 3'b000, 9'o765, 1, 0);
    check("first_data", out_data, 3'o5);
    check("first_src", out_src, 3'b001);
    step(0, 3'b000, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 3'b111, rot_d, 1, 0);
      if (i < 4) check("rot_rdy", obs_rdy, rot_rdy[i]);
      if (i > 0) check("rot_data", out_data, rot_out[i-1]);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 3'b111, 9'o123, 0, 0);
      check("bp_rdy", obs_rdy, 3'b000);
      check("bp_data", out_data, 3'b001);
    end
    step(1, 3'b111, 9'o123, 1, 0);
    check("bp_release", obs_rdy, 3'b100);
    step(0, 3'b000, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 3'b100, 9'o456, 1, 0);
      check("sparse_rdy", obs_rdy, 3'b100);
    end
    step(1, 3'b101, 9'o456, 1, 0);
    check("sparse_p0", obs_rdy, 3'b001);
    step(1, 3'b111, 9'o777, 0, 0);
    step(1, 3'b111, 9'o777, 0, 0);
    step(0, 3'b111, 9'o777, 0, 0);
    step(1, 3'b111, 9'o777, 1, 0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 3'b000);
    check("mid_rst_prio", obs_rdy, 3'b001);
`ifdef MUX1HOT_RR_LOCK_EN
    step(0, 3'b000, '0, 1, 0);
    step(1, 3'b010, 9'o321, 1, 3'b000);
    check("lock_b1", obs_rdy, 3'b010);
    step(1, 3'b111, 9'o321, 1, 3'b000);
    check("lock_b2", obs_rdy, 3'b010);
    step(1, 3'b111, 9'o321, 1, 3'b010);
    check("lock_b3", obs_rdy, 3'b010);
    step(1, 3'b111, 9'o321, 1, 3'b000);
    check("lock_next", obs_rdy, 3'b100);
`endif
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 49) != 0), N'($urandom), N*W'($urandom),
           ($urandom_range(0, 3) != 0), N'($urandom));
    step(1, 3'b000, '0, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux1hot_rr_arbiter.md
# mux1hot_rr_arbiter

Round-robin arbiter that shares one `Mux1hot`-style datapath among `N` requesters and registers the winning requester's data for the consumer. Each cycle at most one requester is granted. The one-hot grant vector drives the select of the team's one-hot mux directly, so the select is one-hot by construction. The block sits between `N` valid/ready producers and a single valid/ready consumer.

## Interface
- `N`, 3: number of requesters; N ≥ 2.
- `WIDTH`, 3: data width per requester.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk`.
- `in_valid`  in  N  per-requester valid.
- `in_data`  in  N*WIDTH  flat data; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N  per-requester ready; one-hot or zero; combinational.
- `out_valid`  out  1  registered output valid.
- `out_ready`  in  1  consumer ready.
- `out_data`  out  WIDTH  registered output data.
- `out_src`  out  N  registered one-hot index of the source of `out_data`.
- `in_last`  in  N  last-beat flag; present only with `MUX1HOT_RR_LOCK_EN`.

## Operation
- State: round-robin pointer `last_gnt` (index, 0..N-1), output register (`out_valid`, `out_data`, `out_src`), lock state when enabled.
- `can_accept` = !out_valid || out_ready.
- Grant: `gnt` is the first i with `in_valid[i]`, searching from last_gnt+1 upward and wrapping modulo N. `gnt` = 0 if no valid.
- `in_ready` = gnt & {N{can_accept}}.
- Data select: `gnt` is the one-hot mux select. The mux output is the OR of the masked inputs, so zero select gives zero data.
- Accept occurs when `|(in_valid & in_ready)`. Then:
  - `out_data` ← muxed data.
  - `out_src` ← gnt.
  - `out_valid` ← 1.
  - `last_gnt` ← winner index.
- No accept and out_ready=1: `out_valid` ← 0. `out_data` and `out_src` hold.
- No valid requester: `last_gnt` is unchanged.
- Never more than one `in_ready` bit set.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `last_gnt`=N-1, so requester 0 has top priority after reset.
  - Lock state is UNLOCKED.
  - `in_ready`=0 while `reset` is low.
- Latency: accept in cycle t gives `out_valid`=1 with that data in cycle t+1.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: while out_valid=1 and out_ready=0, all `in_ready`=0 and the output register holds.
- Simultaneous drain and fill (out_valid=1, out_ready=1, new accept): the output register is replaced in the same cycle with no bubble.
- All requesters valid every cycle: grants rotate 0,1,2,0,…
- Reset asserted mid-stream: a pending output beat is dropped. The next grant after reset goes to the lowest-index valid requester.
- A requester may drop `in_valid` without a grant; no state changes.

## Configuration
- Macro: `MUX1HOT_RR_LOCK_EN`.
- Defined: adds the `in_last` port and a two-state FSM, UNLOCKED → LOCKED(k).
  - In UNLOCKED, arbitrate as above. Accepting a beat from k with in_last[k]=0 moves to LOCKED(k).
  - In LOCKED(k), `gnt` is forced to bit k (or zero if in_valid[k]=0). Other requesters are never granted.
  - Accepting from k with in_last[k]=1 returns to UNLOCKED with last_gnt=k.
  - Reset forces UNLOCKED.
- Undefined: no `in_last` port and no FSM. The block re-arbitrates every beat.

## Test plan
- Reset: reset=0 for 2 cycles with all in_valid=1, then release → during reset in_ready=0 and out_valid=0. First grant in_ready=3'b001; the next cycle gives out_data = requester 0's data and out_src=3'b001.
- Rotation: in_data={3'b010,3'b001,3'b000}, all valid, out_ready=1 → out_data sequence 000,001,010,000, one per cycle, and in_ready sequence 001,010,100,001.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 → out_data and out_src stable, in_ready=000. On release, the next grant follows the pointer.
- Sparse: only requester 2 valid → in_ready=100 each cycle, and last_gnt stays 2. Then assert requester 0 too → requester 0 wins next.
- Reset mid-stream: assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0 and out_data=0, with priority restored to requester 0.
- Lock (`MUX1HOT_RR_LOCK_EN`): requester 1 sends 3 beats with in_last on the 3rd while requesters 0 and 2 are valid → in_ready=010 for all 3 accepts, then the grant goes to requester 2.
